// File: rtl/vic_ctrl_if.sv
// Core-side handshake bundle of the vectored interrupt controller.
//   int_en   : core status bit, interrupts accepted
//   irq      : request to core
//   int_ack  : core accepts irq (single-cycle pulse)
//   eoi      : core executed JEPC, end of interrupt (single-cycle pulse)
//   busy     : handler in service
//   int_addr : vector address of the latched winner
//   int_id   : index of the latched winner
// master = controller side, slave = core side.
interface vic_ctrl_if;
  logic        int_en;
  logic        irq;
  logic        int_ack;
  logic        eoi;
  logic        busy;
  logic [31:0] int_addr;
  logic [2:0]  int_id;

  modport master (
    input  int_en, int_ack, eoi,
    output irq, busy, int_addr, int_id
  );

  modport slave (
    output int_en, int_ack, eoi,
    input  irq, busy, int_addr, int_id
  );
endinterface

// File: rtl/vic_ctrl.sv
// Vectored interrupt controller for the single-cycle MIPS core.
// Turns rising edges on per-peripheral done lines into sticky pending bits,
// picks one enabled source (fixed or rotating priority), raises irq with the
// vector address, and blocks further requests until the handler signals eoi.
//   clk      : system clock, all state on rising edge
//   reset    : asynchronous, active-low
//   done     : level request lines; a rising edge registers an event
//   mask_we  : write strobe for mask
//   mask_wd  : new mask value
//   mask     : current mask (1 = enabled)
//   pending  : pending event bits
//   overrun  : sticky, event arrived while same source already pending
//   ovr_clr  : clears all overrun bits
//   bus      : core handshake (int_en, irq, int_ack, eoi, busy, int_addr, int_id)
module vic_ctrl #(
  parameter int unsigned        NSRC        = 4,
  parameter logic [31:0]        VEC_BASE    = 32'h0000_0100,
  parameter int unsigned        VEC_SHIFT   = 4,
  parameter int unsigned        ROUND_ROBIN = 0,
  parameter logic [NSRC-1:0]    MASK_RST    = {NSRC{1'b1}}
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] done,
  input  logic            mask_we,
  input  logic [NSRC-1:0] mask_wd,
  output logic [NSRC-1:0] mask,
  output logic [NSRC-1:0] pending,
  output logic [NSRC-1:0] overrun,
  input  logic            ovr_clr,
  vic_ctrl_if.master      bus
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t          state;
  logic [NSRC-1:0] done_q;
  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] clr;
  logic [NSRC-1:0] eligible;
  logic [2:0]      rr_ptr;

  logic            lo_found, hi_found;
  logic [2:0]      lo_id, hi_id, win_id;
  logic            win_found;

  assign rise     = done & ~done_q;
  assign eligible = pending & mask;

  // One-hot clear of the granted source, only on an accepted request.
  always_comb begin
    clr = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      clr[i] = (state == REQ) && bus.int_ack && (bus.int_id == 3'(i));
    end
  end

  // Rotating priority = first eligible at or above rr_ptr, else wrap to the
  // lowest eligible index; fixed priority uses the lowest index directly.
  always_comb begin
    lo_found = 1'b0;
    hi_found = 1'b0;
    lo_id    = '0;
    hi_id    = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (eligible[i] && !lo_found) begin
        lo_found = 1'b1;
        lo_id    = 3'(i);
      end
      if (eligible[i] && !hi_found && (32'(rr_ptr) <= i)) begin
        hi_found = 1'b1;
        hi_id    = 3'(i);
      end
    end
    win_found = lo_found;
    win_id    = ((ROUND_ROBIN != 0) && hi_found) ? hi_id : lo_id;
  end

  // Event capture: set beats clear on the same source.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_q  <= '0;
      pending <= '0;
      overrun <= '0;
      mask    <= MASK_RST;
    end else begin
      done_q  <= done;
      pending <= (pending & ~clr) | rise;
      overrun <= (ovr_clr ? '0 : overrun) | (rise & pending & ~clr);
      if (mask_we) begin
        mask <= mask_wd;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      bus.irq      <= 1'b0;
      bus.busy     <= 1'b0;
      bus.int_id   <= '0;
      bus.int_addr <= VEC_BASE;
      rr_ptr       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.int_en && win_found) begin
            bus.int_id   <= win_id;
            bus.int_addr <= VEC_BASE + (32'(win_id) << VEC_SHIFT);
            bus.irq      <= 1'b1;
            state        <= REQ;
          end
        end
        REQ: begin
          if (bus.int_ack) begin
            bus.irq  <= 1'b0;
            bus.busy <= 1'b1;
            rr_ptr   <= (bus.int_id == 3'(NSRC - 1)) ? '0 : bus.int_id + 3'd1;
            state    <= SERVICE;
          end else if (!bus.int_en) begin
            bus.irq <= 1'b0;
            state   <= IDLE;
          end
        end
        SERVICE: begin
          if (bus.eoi) begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          bus.irq  <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vic_ctrl.sv
// Directed bench for vic_ctrl: a fixed-priority instance (dut_a) and a
// round-robin instance (dut_b). Expected grants are queued when stimulus is
// driven and popped when the DUT raises irq.
module tb_vic_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [3:0] done_a, mask_wd_a, mask_a, pending_a, overrun_a;
  logic       mask_we_a, ovr_clr_a;
  logic [3:0] done_b, mask_wd_b, mask_b, pending_b, overrun_b;
  logic       mask_we_b, ovr_clr_b;

  vic_ctrl_if ifa ();
  vic_ctrl_if ifb ();

  vic_ctrl #(.NSRC(4), .VEC_BASE(32'h100), .VEC_SHIFT(4), .ROUND_ROBIN(0), .MASK_RST(4'hF)) dut_a (
    .clk(clk), .reset(reset), .done(done_a), .mask_we(mask_we_a), .mask_wd(mask_wd_a),
    .mask(mask_a), .pending(pending_a), .overrun(overrun_a), .ovr_clr(ovr_clr_a), .bus(ifa.master));

  vic_ctrl #(.NSRC(4), .VEC_BASE(32'h100), .VEC_SHIFT(4), .ROUND_ROBIN(1), .MASK_RST(4'hF)) dut_b (
    .clk(clk), .reset(reset), .done(done_b), .mask_we(mask_we_b), .mask_wd(mask_wd_b),
    .mask(mask_b), .pending(pending_b), .overrun(overrun_b), .ovr_clr(ovr_clr_b), .bus(ifb.master));

  typedef struct packed {logic [2:0] id; logic [31:0] addr;} grant_t;
  grant_t qa[$];
  grant_t qb[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  function automatic grant_t mk(input int id);
    grant_t g;
    g.id   = 3'(id);
    g.addr = 32'h100 + (32'(id) << 4);
    return g;
  endfunction

  task automatic wait_grant_a(input string tag);
    grant_t g;
    int n = 0;
    while (ifa.irq !== 1'b1 && n < 20) begin cyc(); n++; end
    chk({tag, " irq"}, 32'(ifa.irq), 32'd1);
    if (qa.size() == 0) begin
      chk({tag, " queue"}, 32'd0, 32'd1);
    end else begin
      g = qa.pop_front();
      chk({tag, " id"}, 32'(ifa.int_id), 32'(g.id));
      chk({tag, " addr"}, ifa.int_addr, g.addr);
    end
  endtask

  task automatic ack_a(input string tag);
    ifa.int_ack = 1'b1; cyc(); ifa.int_ack = 1'b0;
    chk({tag, " busy"}, 32'(ifa.busy), 32'd1);
    chk({tag, " irq_off"}, 32'(ifa.irq), 32'd0);
  endtask

  task automatic eoi_a(input string tag);
    ifa.eoi = 1'b1; cyc(); ifa.eoi = 1'b0;
    chk({tag, " idle"}, 32'(ifa.busy), 32'd0);
  endtask

  task automatic serve_a(input string tag);
    wait_grant_a(tag);
    ack_a(tag);
    eoi_a(tag);
  endtask

  task automatic pulse_a(input logic [3:0] v);
    done_a = v; cyc(); done_a = '0; cyc();
  endtask

  // Round-robin service; both sources re-pulsed while the handler runs.
  task automatic serve_b(input string tag);
    grant_t g;
    int n = 0;
    while (ifb.irq !== 1'b1 && n < 20) begin cyc(); n++; end
    chk({tag, " irq"}, 32'(ifb.irq), 32'd1);
    if (qb.size() == 0) begin
      chk({tag, " queue"}, 32'd0, 32'd1);
    end else begin
      g = qb.pop_front();
      chk({tag, " id"}, 32'(ifb.int_id), 32'(g.id));
      chk({tag, " addr"}, ifb.int_addr, g.addr);
    end
    ifb.int_ack = 1'b1; cyc(); ifb.int_ack = 1'b0;
    done_b = 4'b0011; cyc(); done_b = '0; cyc();
    ifb.eoi = 1'b1; cyc(); ifb.eoi = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    done_a = '0; mask_we_a = 1'b0; mask_wd_a = '0; ovr_clr_a = 1'b0;
    done_b = '0; mask_we_b = 1'b0; mask_wd_b = '0; ovr_clr_b = 1'b0;
    ifa.int_en = 1'b0; ifa.int_ack = 1'b0; ifa.eoi = 1'b0;
    ifb.int_en = 1'b0; ifb.int_ack = 1'b0; ifb.eoi = 1'b0;
    cyc(); cyc();

    // Reset values
    chk("rst irq", 32'(ifa.irq), 32'd0);
    chk("rst busy", 32'(ifa.busy), 32'd0);
    chk("rst pending", 32'(pending_a), 32'd0);
    chk("rst overrun", 32'(overrun_a), 32'd0);
    chk("rst mask", 32'(mask_a), 32'hF);
    chk("rst addr", ifa.int_addr, 32'h100);
    chk("rst id", 32'(ifa.int_id), 32'd0);
    reset = 1'b1;
    cyc();

    // Single source, exact latency
    ifa.int_en = 1'b1;
    qa.push_back(mk(2));
    done_a = 4'b0100; cyc();
    chk("lat pending", 32'(pending_a), 32'h4);
    chk("lat irq_early", 32'(ifa.irq), 32'd0);
    done_a = '0; cyc();
    chk("lat irq", 32'(ifa.irq), 32'd1);
    wait_grant_a("single");
    ack_a("single");
    chk("single pending_clr", 32'(pending_a), 32'd0);
    eoi_a("single");

    // Fixed priority: 1 before 3
    qa.push_back(mk(1));
    qa.push_back(mk(3));
    pulse_a(4'b1010);
    serve_a("fixed1");
    serve_a("fixed3");

    // Round robin on dut_b: alternating 0,1,0,1
    ifb.int_en = 1'b1;
    qb.push_back(mk(0)); qb.push_back(mk(1));
    qb.push_back(mk(0)); qb.push_back(mk(1));
    done_b = 4'b0011; cyc(); done_b = '0;
    for (int i = 0; i < 4; i++) serve_b($sformatf("rr%0d", i));

    // Masked source latches pending but is not requested
    mask_we_a = 1'b1; mask_wd_a = 4'b1011; cyc(); mask_we_a = 1'b0;
    chk("mask wr", 32'(mask_a), 32'hB);
    pulse_a(4'b0100);
    cyc(); cyc();
    chk("mask pending", 32'(pending_a), 32'h4);
    chk("mask no_irq", 32'(ifa.irq), 32'd0);
    qa.push_back(mk(2));
    mask_we_a = 1'b1; mask_wd_a = 4'b1111; cyc(); mask_we_a = 1'b0;
    serve_a("unmask");

    // Overrun and level-held done
    ifa.int_en = 1'b0;
    pulse_a(4'b0100);
    pulse_a(4'b0100);
    chk("ovr set", 32'(overrun_a), 32'h4);
    chk("ovr pending", 32'(pending_a), 32'h4);
    ovr_clr_a = 1'b1; cyc(); ovr_clr_a = 1'b0;
    chk("ovr clr", 32'(overrun_a), 32'd0);
    done_a = 4'b0001;
    repeat (10) cyc();
    done_a = '0; cyc();
    chk("level pending", 32'(pending_a), 32'h5);
    chk("level no_ovr", 32'(overrun_a), 32'd0);
    qa.push_back(mk(0));
    qa.push_back(mk(2));
    ifa.int_en = 1'b1;
    serve_a("level0");
    serve_a("level2");
    chk("level drained", 32'(pending_a), 32'd0);

    // int_en withdrawal during REQ
    mask_we_a = 1'b1; mask_wd_a = 4'b0111; cyc(); mask_we_a = 1'b0;
    qa.push_back(mk(1));
    pulse_a(4'b0010);
    wait_grant_a("withdraw");
    ifa.int_en = 1'b0; cyc();
    chk("withdraw irq", 32'(ifa.irq), 32'd0);
    chk("withdraw pending", 32'(pending_a), 32'h2);
    qa.push_back(mk(1));
    ifa.int_en = 1'b1;
    wait_grant_a("reenable");
    ack_a("reenable");

    // Asynchronous reset in SERVICE
    reset = 1'b0;
    #1;
    chk("arst busy", 32'(ifa.busy), 32'd0);
    chk("arst irq", 32'(ifa.irq), 32'd0);
    chk("arst id", 32'(ifa.int_id), 32'd0);
    chk("arst addr", ifa.int_addr, 32'h100);
    chk("arst mask", 32'(mask_a), 32'hF);
    chk("arst pending", 32'(pending_a), 32'd0);
    chk("arst queue", 32'(qa.size()), 32'd0);
    cyc();
    reset = 1'b1;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
